lsu_dmem: RTL and testbench

LSU_DMEM -- requirements
Module: lsu_dmem

---
 rtl/rv32_mem_pkg.sv | 64 ++++++
 rtl/dmem_bank.sv | 29 ++
 rtl/lsu_dmem.sv | 134 +++++++++++++
 tb/tb_lsu_dmem.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared RV32I load/store definitions for the data-memory LSU.
//   mem_funct3_e  : load/store width encodings (funct3 field)
//   lsu_state_e   : LSU sequencing states
//   access_legal  : funct3 legality and natural alignment for a request
//   byte_en       : byte-lane write enables for a store
//   store_lanes   : right-aligned store data moved onto its byte lanes
//   load_ext      : lane select plus sign/zero extension for a load
package rv32_mem_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } mem_funct3_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } lsu_state_e;

   // Unsigned widths only exist for loads, so a store with 100/101 is illegal.
   function automatic logic access_legal(logic we, logic [2:0] funct3, logic [1:0] off);
      case (funct3)
         F3_B:    return 1'b1;
         F3_H:    return ~off[0];
         F3_W:    return off == 2'b00;
         F3_BU:   return ~we;
         F3_HU:   return ~we & ~off[0];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(logic [2:0] funct3, logic [1:0] off);
      logic [3:0] lanes;
      case (funct3)
         F3_B:    lanes = 4'b0001;
         F3_H:    lanes = 4'b0011;
         F3_W:    lanes = 4'b1111;
         default: lanes = 4'b0000;
      endcase
      return lanes << off;
   endfunction

   function automatic logic [31:0] store_lanes(logic [31:0] wdata, logic [1:0] off);
      return wdata << {off, 3'b000};
   endfunction

   function automatic logic [31:0] load_ext(logic [2:0] funct3, logic [31:0] word, logic [1:0] off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (funct3)
         F3_B:    return {{24{sh[7]}}, sh[7:0]};
         F3_H:    return {{16{sh[15]}}, sh[15:0]};
         F3_W:    return sh;
         F3_BU:   return {24'h0, sh[7:0]};
         F3_HU:   return {16'h0, sh[15:0]};
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH_WORDS x 32 data RAM, synchronous byte-lane write, combinational read.
//   clk   : write clock
//   be    : per-byte write enables (bit i writes wdata[8i+7:8i])
//   addr  : word index, shared by read and write
//   wdata : lane-aligned write data
//   rdata : word at addr, combinational
// Contents are deliberately not reset.
module dmem_bank #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit in front of a single-port data RAM with fixed wait states.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake (ready only while idle)
//   req_we, req_funct3       : store/load and RV32I width encoding
//   req_addr, req_wdata      : byte address, right-aligned store data
//   rsp_valid                : one-cycle response pulse
//   rsp_rdata, rsp_err       : extended load data, reject flag
//
// state   | meaning
// IDLE    | ready for a request; accept captures all request fields
// WAIT    | wait states; cnt counts down to 0
// RESP    | response presented for one cycle; store already committed
module lsu_dmem
   import rv32_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS) << 2;
   localparam logic [2:0]  CNT_INIT  = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

   lsu_state_e  state;
   logic [2:0]  cnt;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic        cur_we;
   logic [2:0]  cur_funct3;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [31:0] off;
   logic        acc_err;
   logic        enter_resp;
   logic [3:0]  bank_be;
   logic [31:0] bank_rdata;
   logic [31:0] rdata_nxt;

   assign req_ready = (state == ST_IDLE);

   // With zero wait states the access completes on the accept edge itself,
   // so the live request drives the datapath while idle.
   always_comb begin
      cur_we     = req_ready ? req_we     : we_q;
      cur_funct3 = req_ready ? req_funct3 : funct3_q;
      cur_addr   = req_ready ? req_addr   : addr_q;
      cur_wdata  = req_ready ? req_wdata  : wdata_q;
      // Below-base addresses wrap to huge offsets and fail the range test.
      off        = cur_addr - BASE_ADDR;
      acc_err    = !(off < MEM_BYTES) || !access_legal(cur_we, cur_funct3, off[1:0]);
      enter_resp = (req_ready && req_valid && WAIT_CYCLES == 0) ||
                   (state == ST_WAIT && cnt == 3'd0);
      bank_be    = (enter_resp && cur_we && !acc_err && !rst) ?
                   byte_en(cur_funct3, off[1:0]) : 4'b0000;
      rdata_nxt  = (acc_err || cur_we) ? 32'h0 :
                   load_ext(cur_funct3, bank_rdata, off[1:0]);
   end

   dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
      .clk   (clk),
      .be    (bank_be),
      .addr  (off[AW+1:2]),
      .wdata (store_lanes(cur_wdata, off[1:0])),
      .rdata (bank_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 3'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         we_q      <= 1'b0;
         funct3_q  <= 3'd0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= acc_err;
                     rsp_rdata <= rdata_nxt;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 3'd0) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= acc_err;
                  rsp_rdata <= rdata_nxt;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            ST_RESP: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= 32'h0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: instance 0 uses defaults (1024 words, 1 wait state,
// base 0); instance 1 uses 16 words, no wait states, base 0x1000.
module tb_lsu_dmem;

   logic        clk;
   logic        rst_s       [2];
   logic        req_valid_s [2];
   logic        req_we_s    [2];
   logic [2:0]  req_funct3_s[2];
   logic [31:0] req_addr_s  [2];
   logic [31:0] req_wdata_s [2];
   logic        req_ready_s [2];
   logic        rsp_valid_s [2];
   logic [31:0] rsp_rdata_s [2];
   logic        rsp_err_s   [2];

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem_a [int];
   logic [31:0] mem_b [int];

   lsu_dmem u_dut_a (
      .clk        (clk),
      .rst        (rst_s[0]),
      .req_valid  (req_valid_s[0]),
      .req_ready  (req_ready_s[0]),
      .req_we     (req_we_s[0]),
      .req_funct3 (req_funct3_s[0]),
      .req_addr   (req_addr_s[0]),
      .req_wdata  (req_wdata_s[0]),
      .rsp_valid  (rsp_valid_s[0]),
      .rsp_rdata  (rsp_rdata_s[0]),
      .rsp_err    (rsp_err_s[0])
   );

   lsu_dmem #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) u_dut_b (
      .clk        (clk),
      .rst        (rst_s[1]),
      .req_valid  (req_valid_s[1]),
      .req_ready  (req_ready_s[1]),
      .req_we     (req_we_s[1]),
      .req_funct3 (req_funct3_s[1]),
      .req_addr   (req_addr_s[1]),
      .req_wdata  (req_wdata_s[1]),
      .rsp_valid  (rsp_valid_s[1]),
      .rsp_rdata  (rsp_rdata_s[1]),
      .rsp_err    (rsp_err_s[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h", name, got, exp);
      end
   endtask

   // Reference: byte-addressed memory semantics from the width/alignment/range rules.
   task automatic model_access(input int d, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rd, output logic er);
      longint base, span, a, v;
      int size, idx, off;
      bit sgn, legal;
      logic [31:0] w;
      base = (d == 0) ? 64'h0 : 64'h1000;
      span = (d == 0) ? 64'd4096 : 64'd64;
      size = 1; sgn = 1'b0; legal = 1'b1;
      case (f3)
         3'd0: begin size = 1; sgn = 1'b1; end
         3'd1: begin size = 2; sgn = 1'b1; end
         3'd2: size = 4;
         3'd4: begin size = 1; legal = !we; end
         3'd5: begin size = 2; legal = !we; end
         default: legal = 1'b0;
      endcase
      a  = {32'h0, addr};
      er = !legal || (a % size != 0) || (a < base) || (a >= base + span);
      rd = 32'h0;
      if (er) return;
      idx = int'((a - base) / 4);
      off = int'(a % 4);
      if (d == 0) w = mem_a.exists(idx) ? mem_a[idx] : 32'h0;
      else        w = mem_b.exists(idx) ? mem_b[idx] : 32'h0;
      if (we) begin
         for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
         if (d == 0) mem_a[idx] = w;
         else        mem_b[idx] = w;
      end else begin
         v = ({32'h0, w} >> (8*off)) & ((64'd1 << (8*size)) - 1);
         if (sgn && v >= (64'd1 << (8*size - 1))) v = v - (64'd1 << (8*size));
         rd = v[31:0];
      end
   endtask

   // One full request on an idle DUT, with handshake and latency checks.
   task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er);
      int lat;
      bit seen;
      lat = (d == 0) ? 1 : 0;
      @(negedge clk);
      check("ready_idle", 32'(req_ready_s[d]), 32'd1);
      req_we_s[d] = we; req_funct3_s[d] = f3; req_addr_s[d] = addr; req_wdata_s[d] = wdata;
      req_valid_s[d] = 1'b1;
      @(posedge clk);
      #1 req_valid_s[d] = 1'b0;
      seen = 1'b0; rd = 32'h0; er = 1'b0;
      for (int k = 1; k <= 12 && !seen; k++) begin
         @(negedge clk);
         if (rsp_valid_s[d]) begin
            seen = 1'b1;
            check("rsp_latency", 32'(k), 32'(lat + 1));
            check("ready_in_resp", 32'(req_ready_s[d]), 32'd0);
            rd = rsp_rdata_s[d];
            er = rsp_err_s[d];
         end else begin
            check("ready_busy", 32'(req_ready_s[d]), 32'd0);
         end
      end
      if (!seen) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_timeout: dut %0d no rsp_valid within 12 cycles, expected one", d);
      end else begin
         @(negedge clk);
         check("rsp_pulse_width", 32'(rsp_valid_s[d]), 32'd0);
         check("ready_after_rsp", 32'(req_ready_s[d]), 32'd1);
      end
   endtask

   task automatic run_model(input int d, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] exp_rd, got_rd;
      logic        exp_er, got_er;
      model_access(d, we, f3, addr, wdata, exp_rd, exp_er);
      do_req(d, we, f3, addr, wdata, got_rd, got_er);
      check($sformatf("rdata d%0d we%0d f3=%0d a=%08h", d, we, f3, addr), got_rd, exp_rd);
      check($sformatf("err d%0d we%0d f3=%0d a=%08h", d, we, f3, addr), 32'(got_er), 32'(exp_er));
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_er;
   } vec_t;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } breq_t;

   initial begin
      vec_t        tbl[$];
      breq_t       bq[$];
      logic [31:0] got_rd, dummy_rd, addr;
      logic        got_er, dummy_er;
      logic [2:0]  f3;
      logic        we;

      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b1; req_valid_s[d] = 1'b0; req_we_s[d] = 1'b0;
         req_funct3_s[d] = 3'd0; req_addr_s[d] = 32'h0; req_wdata_s[d] = 32'h0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_rsp_valid", 32'(rsp_valid_s[d]), 32'd0);
         check("rst_rsp_rdata", rsp_rdata_s[d], 32'h0);
         check("rst_rsp_err", 32'(rsp_err_s[d]), 32'd0);
         check("rst_ready", 32'(req_ready_s[d]), 32'd1);
      end
      rst_s[0] = 1'b0; rst_s[1] = 1'b0;

      // Directed vectors on instance 0
      tbl.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 3'b000, 32'h13, 32'h80,       32'h0,        1'b0});
      tbl.push_back('{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0});
      tbl.push_back('{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0});
      tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0});
      tbl.push_back('{1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b1, 3'b010, 32'h12, 32'h1,        32'h0,        1'b1});
      tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0});
      tbl.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,      32'h0,        1'b1});
      tbl.push_back('{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1});
      tbl.push_back('{1'b1, 3'b110, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1});
      tbl.push_back('{1'b1, 3'b010, 32'h0E, 32'h12345678, 32'h0,        1'b1});
      tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0});
      tbl.push_back('{1'b1, 3'b001, 32'h12, 32'h12348001, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001, 1'b0});
      tbl.push_back('{1'b0, 3'b101, 32'h12, 32'h0,        32'h00008001, 1'b0});
      tbl.push_back('{1'b1, 3'b000, 32'h10, 32'hFFFFFF11, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0});
      tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h8001BE11, 1'b0});
      tbl.push_back('{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,  32'h0,        1'b1});
      for (int i = 0; i < tbl.size(); i++) begin
         model_access(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, dummy_rd, dummy_er);
         do_req(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, got_rd, got_er);
         check($sformatf("vec%0d_rdata", i), got_rd, tbl[i].exp_rd);
         check($sformatf("vec%0d_err", i), 32'(got_er), 32'(tbl[i].exp_er));
      end

      // Randomized traffic on instance 0 against the model
      for (int w = 0; w < 32; w++) run_model(0, 1'b1, 3'b010, 32'(w * 4), $urandom);
      run_model(0, 1'b1, 3'b010, 32'hFFC, $urandom);
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(7, 0))
            6:       addr = 32'hFFC + 32'($urandom_range(7, 0));
            7:       addr = $urandom;
            default: addr = 32'($urandom_range(127, 0));
         endcase
         if (addr >= 32'h80 && addr < 32'hFFC) addr = 32'h2000;
         f3 = 3'($urandom_range(7, 0));
         we = 1'($urandom_range(1, 0));
         run_model(0, we, f3, addr, $urandom);
      end

      // Reset while a store is waiting: store dropped, no response
      @(negedge clk);
      req_we_s[0] = 1'b1; req_funct3_s[0] = 3'b010; req_addr_s[0] = 32'h20; req_wdata_s[0] = 32'h5;
      req_valid_s[0] = 1'b1;
      @(posedge clk);
      #1 req_valid_s[0] = 1'b0;
      @(negedge clk);
      check("abort_ready_in_wait", 32'(req_ready_s[0]), 32'd0);
      rst_s[0] = 1'b1;
      @(negedge clk);
      rst_s[0] = 1'b0;
      check("abort_ready_after_rst", 32'(req_ready_s[0]), 32'd1);
      check("abort_no_rsp", 32'(rsp_valid_s[0]), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("abort_no_late_rsp", 32'(rsp_valid_s[0]), 32'd0);
      end
      run_model(0, 1'b0, 3'b010, 32'h20, 32'h0);

      // Instance 1: back-to-back requests held until accepted
      bq.push_back('{1'b1, 3'b010, 32'h1000, 32'h11112222});
      bq.push_back('{1'b1, 3'b010, 32'h1004, 32'h33334444});
      bq.push_back('{1'b0, 3'b010, 32'h1000, 32'h0});
      bq.push_back('{1'b0, 3'b001, 32'h1006, 32'h0});
      bq.push_back('{1'b0, 3'b010, 32'h1040, 32'h0});
      bq.push_back('{1'b0, 3'b010, 32'h0FFC, 32'h0});
      bq.push_back('{1'b1, 3'b000, 32'h1007, 32'hF0});
      bq.push_back('{1'b0, 3'b000, 32'h1007, 32'h0});
      bq.push_back('{1'b0, 3'b010, 32'h1004, 32'h0});
      bq.push_back('{1'b1, 3'b010, 32'h103C, 32'hAABBCCDD});
      bq.push_back('{1'b0, 3'b101, 32'h103E, 32'h0});
      bq.push_back('{1'b0, 3'b010, 32'h1002, 32'h0});
      begin
         logic [31:0] q_rd[$];
         logic        q_er[$];
         logic [31:0] e_rd;
         logic        e_er;
         int idx, acc_cyc, cyc;
         idx = 0; acc_cyc = -10; cyc = 0;
         while (cyc < 80 && (idx < bq.size() || q_rd.size() > 0)) begin
            @(negedge clk);
            if (rsp_valid_s[1]) begin
               check("b_rsp_after_accept", 32'(cyc), 32'(acc_cyc + 1));
               if (q_rd.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL b_spurious_rsp: rsp_valid=1 at cycle %0d, expected 0", cyc);
               end else begin
                  e_rd = q_rd.pop_front();
                  e_er = q_er.pop_front();
                  check("b_rdata", rsp_rdata_s[1], e_rd);
                  check("b_err", 32'(rsp_err_s[1]), 32'(e_er));
               end
            end
            if (idx < bq.size()) begin
               req_we_s[1] = bq[idx].we; req_funct3_s[1] = bq[idx].f3;
               req_addr_s[1] = bq[idx].addr; req_wdata_s[1] = bq[idx].wdata;
               req_valid_s[1] = 1'b1;
               if (req_ready_s[1]) begin
                  if (idx > 0) check("b_accept_gap", 32'(cyc - acc_cyc), 32'd2);
                  acc_cyc = cyc;
                  model_access(1, bq[idx].we, bq[idx].f3, bq[idx].addr, bq[idx].wdata, e_rd, e_er);
                  q_rd.push_back(e_rd);
                  q_er.push_back(e_er);
                  idx++;
               end
            end else begin
               req_valid_s[1] = 1'b0;
            end
            cyc++;
         end
         req_valid_s[1] = 1'b0;
         if (idx < bq.size() || q_rd.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_stream_timeout: %0d accepted, %0d responses pending, expected %0d and 0",
                     idx, q_rd.size(), bq.size());
         end
      end

      // A few more randomized requests on instance 1
      for (int n = 0; n < 30; n++) begin
         addr = 32'h0FF8 + 32'($urandom_range(79, 0));
         f3 = 3'($urandom_range(7, 0));
         we = 1'($urandom_range(1, 0));
         if (!we && (addr < 32'h1000 || addr >= 32'h1040 ||
                     !mem_b.exists(int'((addr - 32'h1000) >> 2)))) begin
            we = 1'b1;
         end
         run_model(1, we, f3, addr, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
